// File: rtl/bram_arb_pkg.sv
// ============================================================================
// Module  : bram_arb_pkg
// Brief   : Shared types, constants and round-robin pick for the BRAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_arb_pkg;

  localparam int RSP_LATENCY = 2;
  localparam int MAX_REQ     = 16;
  localparam int ID_WIDTH    = 4;

  typedef struct packed {
    logic                vld;
    logic                isRead;
    logic [ID_WIDTH-1:0] id;
  } arb_tag_t;

  // One-hot grant for the first set bit of valid at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  valid,
    input logic [ID_WIDTH-1:0] ptr,
    input int                  n
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int                 idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found) begin
        if (valid[idx[ID_WIDTH-1:0]]) begin
          grant[idx[ID_WIDTH-1:0]] = 1'b1;
          found                    = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin grant with a registered rotating pointer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_valid,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_grantId,
  output logic                 o_any
);

  localparam int IDW = $clog2(N);

  logic [IDW-1:0]      r_ptr;
  logic [MAX_REQ-1:0]  w_validExt;
  logic [ID_WIDTH-1:0] w_ptrExt;
  logic [MAX_REQ-1:0]  w_pick;

  always_comb begin
    w_validExt          = '0;
    w_validExt[N-1:0]   = i_valid;
    w_ptrExt            = '0;
    w_ptrExt[IDW-1:0]   = r_ptr;
  end

  assign w_pick  = rr_pick(w_validExt, w_ptrExt, N);
  assign o_grant = w_pick[N-1:0];
  assign o_any   = |w_pick;

  always_comb begin
    o_grantId = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick[i]) o_grantId = IDW'(i);
    end
  end

  // A grant is always a handshake because only valid requesters are granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= (o_grantId == IDW'(N - 1)) ? '0 : o_grantId + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_arb_rw.sv
// ============================================================================
// Module  : bram_arb_rw
// Brief   : Round-robin multiplexer of NUM_REQ clients onto BRAM port A with
//           2-cycle read response routing. Option macro: BRAM_ARB_WR_ACK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_arb_rw
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                          clockIn,
  input  logic                          resetNIn,
  input  logic [NUM_REQ-1:0]            reqValidIn,
  output logic [NUM_REQ-1:0]            reqReadyOut,
  input  logic [NUM_REQ-1:0]            reqWrIn,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddrIn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn,
  output logic [NUM_REQ-1:0]            rspValidOut,
  output logic [DATA_WIDTH-1:0]         rspDataOut,
  output logic                          bramEnOut,
  output logic                          bramWrEnOut,
  output logic [ADDR_WIDTH-1:0]         bramAddrOut,
  output logic [DATA_WIDTH-1:0]         bramDataOut,
  input  logic [DATA_WIDTH-1:0]         bramDataIn
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    w_grant;
  logic [IDW-1:0]        w_gid;
  logic                  w_hs;
  logic [ADDR_WIDTH-1:0] w_selAddr;
  logic [DATA_WIDTH-1:0] w_selData;
  logic                  w_selWr;
  arb_tag_t              w_newTag;
  arb_tag_t              w_tagOut;
  logic                  w_rspFire;

  logic                  r_bramEn;
  logic                  r_bramWrEn;
  logic [ADDR_WIDTH-1:0] r_bramAddr;
  logic [DATA_WIDTH-1:0] r_bramData;
  logic [DATA_WIDTH-1:0] r_rspHold;
  arb_tag_t              r_tag [RSP_LATENCY];

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk       (clockIn),
    .rst_n     (resetNIn),
    .i_valid   (reqValidIn),
    .o_grant   (w_grant),
    .o_grantId (w_gid),
    .o_any     (w_hs)
  );

  assign reqReadyOut = w_grant;
  assign w_selAddr   = reqAddrIn[int'(w_gid)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_selData   = reqDataIn[int'(w_gid)*DATA_WIDTH +: DATA_WIDTH];
  assign w_selWr     = reqWrIn[w_gid];

  always_comb begin
    w_newTag             = '0;
    w_newTag.vld         = w_hs;
    w_newTag.isRead      = ~w_selWr;
    w_newTag.id[IDW-1:0] = w_gid;
  end

  // Address and data hold when idle so the BRAM pins only toggle on real accesses.
  always_ff @(posedge clockIn or negedge resetNIn) begin
    if (!resetNIn) begin
      r_bramEn   <= 1'b0;
      r_bramWrEn <= 1'b0;
      r_bramAddr <= '0;
      r_bramData <= '0;
    end else if (w_hs) begin
      r_bramEn   <= 1'b1;
      r_bramWrEn <= w_selWr;
      r_bramAddr <= w_selAddr;
      r_bramData <= w_selData;
    end else begin
      r_bramEn   <= 1'b0;
      r_bramWrEn <= 1'b0;
    end
  end

  always_ff @(posedge clockIn or negedge resetNIn) begin
    if (!resetNIn) begin
      for (int s = 0; s < RSP_LATENCY; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= w_newTag;
      for (int s = 1; s < RSP_LATENCY; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  assign w_tagOut = r_tag[RSP_LATENCY-1];

`ifdef BRAM_ARB_WR_ACK_EN
  assign w_rspFire = w_tagOut.vld;
`else
  assign w_rspFire = w_tagOut.vld & w_tagOut.isRead;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp_strobe
    assign rspValidOut[i] = w_rspFire && (w_tagOut.id == ID_WIDTH'(i));
  end

  // Response data passes straight from the BRAM; the hold register only covers idle cycles.
  always_ff @(posedge clockIn or negedge resetNIn) begin
    if (!resetNIn) begin
      r_rspHold <= '0;
    end else if (w_rspFire) begin
      r_rspHold <= bramDataIn;
    end
  end

  assign rspDataOut  = w_rspFire ? bramDataIn : r_rspHold;
  assign bramEnOut   = r_bramEn;
  assign bramWrEnOut = r_bramWrEn;
  assign bramAddrOut = r_bramAddr;
  assign bramDataOut = r_bramData;

endmodule

`default_nettype wire

// File: tb/tb_bram_arb_rw.sv
// ============================================================================
// Module  : tb_bram_arb_rw
// Brief   : Randomized and directed checking of bram_arb_rw against a
//           transaction-level model with a write-first BRAM behind port A.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_arb_rw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid;
  logic [3:0]  wr;
  logic [15:0] addr;
  logic [31:0] data;
  logic [3:0]  ready;
  logic [3:0]  rspV;
  logic [7:0]  rspD;
  logic        bEn;
  logic        bWe;
  logic [3:0]  bAddr;
  logic [7:0]  bData;
  logic [7:0]  bIn;
  logic [7:0]  bram_mem [16];

  bram_arb_rw #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4)
  ) dut (
    .clockIn     (clk),
    .resetNIn    (rst_n),
    .reqValidIn  (valid),
    .reqReadyOut (ready),
    .reqWrIn     (wr),
    .reqAddrIn   (addr),
    .reqDataIn   (data),
    .rspValidOut (rspV),
    .rspDataOut  (rspD),
    .bramEnOut   (bEn),
    .bramWrEnOut (bWe),
    .bramAddrOut (bAddr),
    .bramDataOut (bData),
    .bramDataIn  (bIn)
  );

  always #5 clk = ~clk;

  // Write-first BRAM with a registered read.
  always @(posedge clk) begin
    if (bEn) begin
      if (bWe) begin
        bram_mem[bAddr] <= bData;
        bIn             <= bData;
      end else begin
        bIn <= bram_mem[bAddr];
      end
    end
  end

  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } rsp_t;

  rsp_t       exp_q [$];
  logic [7:0] ref_mem [16];
  int         ptr;
  int         cyc;
  logic       iss_en, iss_we;
  logic [3:0] iss_addr;
  logic [7:0] iss_data;
  logic [7:0] last_rsp;
  int         n_chk  = 0;
  int         n_pass = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    ptr      = 0;
    iss_en   = 1'b0;
    iss_we   = 1'b0;
    iss_addr = '0;
    iss_data = '0;
    last_rsp = '0;
  endtask

  task automatic check_outputs();
    logic [3:0] ev;
    logic [7:0] ed;
    ev = 4'b0;
    ed = last_rsp;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ev       = 4'b1 << exp_q[0].id;
      ed       = exp_q[0].data;
      last_rsp = ed;
      void'(exp_q.pop_front());
    end
    chk("rspValid", 32'(rspV), 32'(ev));
    chk("rspData", 32'(rspD), 32'(ed));
    chk("bramEn", 32'(bEn), 32'(iss_en));
    chk("bramWrEn", 32'(bWe), 32'(iss_we));
    chk("bramAddr", 32'(bAddr), 32'(iss_addr));
    chk("bramData", 32'(bData), 32'(iss_data));
  endtask

  // One clock cycle: check outputs, apply a request set, check the grant, update the model.
  task automatic step(input logic [3:0] v, input logic [3:0] w, input logic [15:0] a,
                      input logic [31:0] d, output int g);
    logic [3:0] eg;
    rsp_t       r;
    @(negedge clk);
    cyc++;
    check_outputs();
    valid = v;
    wr    = w;
    addr  = a;
    data  = d;
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && v[(ptr + k) % 4]) g = (ptr + k) % 4;
    end
    eg = (g >= 0) ? (4'b1 << g) : 4'b0;
    chk("reqReady", 32'(ready), 32'(eg));
    if (g >= 0) begin
      iss_en   = 1'b1;
      iss_we   = w[g];
      iss_addr = a[4*g +: 4];
      iss_data = d[8*g +: 8];
      ptr      = (g + 1) % 4;
      r.due    = cyc + 2;
      r.id     = g;
      if (w[g]) begin
        ref_mem[iss_addr] = iss_data;
        r.data = iss_data;
`ifdef BRAM_ARB_WR_ACK_EN
        exp_q.push_back(r);
`endif
      end else begin
        r.data = ref_mem[iss_addr];
        exp_q.push_back(r);
      end
    end else begin
      iss_en = 1'b0;
      iss_we = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) step(4'b0, 4'b0, 16'h0, 32'h0, g);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    cyc++;
    check_outputs();
    rst_n = 1'b0;
    valid = 4'b0;
    model_clear();
    @(negedge clk);
    cyc++;
    check_outputs();
    rst_n = 1'b1;
  endtask

  logic [3:0]  cv, cw;
  logic [15:0] ca;
  logic [31:0] cd;
  int          g;

  initial begin
    rst_n = 1'b0;
    valid = '0;
    wr    = '0;
    addr  = '0;
    data  = '0;
    bIn   = '0;
    cyc   = 0;
    for (int i = 0; i < 16; i++) begin
      bram_mem[i] = 8'h00;
      ref_mem[i]  = 8'h00;
    end
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_rspValid", 32'(rspV), 32'h0);
    chk("rst_rspData", 32'(rspD), 32'h0);
    chk("rst_bramEn", 32'(bEn), 32'h0);
    chk("rst_bramAddr", 32'(bAddr), 32'h0);
    rst_n = 1'b1;

    idle(10);

    // Client 1 writes 0xA5 to addr 3, then client 2 reads it back.
    step(4'b0010, 4'b0010, 16'h0030, 32'h0000_A500, g);
    step(4'b0100, 4'b0000, 16'h0300, 32'h0, g);
    idle(4);

    // Preload addr i with 0x10+i, then all four read with the pointer at 0.
    for (int i = 0; i < 4; i++) begin
      ca = 16'(i) << (4 * i);
      cd = (32'h10 + 32'(i)) << (8 * i);
      step(4'b1 << i, 4'b1 << i, ca, cd, g);
    end
    for (int i = 0; i < 5; i++) step(4'b1111, 4'b0000, 16'h3210, 32'h0, g);
    idle(3);

    // Move pointer to 3, then only clients 0 and 3 compete.
    step(4'b0100, 4'b0000, 16'h0500, 32'h0, g);
    for (int i = 0; i < 3; i++) step(4'b1001, 4'b0000, 16'h7006, 32'h0, g);
    idle(3);

    // Write from client 0 (acknowledged only with the write-ack option).
    step(4'b0001, 4'b0001, 16'h0009, 32'h0000_003C, g);
    idle(3);

    // Read accepted, then reset: the response must never appear.
    step(4'b0001, 4'b0000, 16'h0003, 32'h0, g);
    pulse_reset();
    idle(3);
    step(4'b1111, 4'b0000, 16'h0123, 32'h0, g);
    idle(3);

    // Randomized traffic; payload stays stable until accepted or dropped.
    cv = '0; cw = '0; ca = '0; cd = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!cv[i] || g == i || ($urandom_range(0, 9) == 0)) begin
          cv[i]          = ($urandom_range(0, 9) < 6);
          cw[i]          = $urandom_range(0, 1) == 1;
          ca[4*i +: 4]   = 4'($urandom_range(0, 15));
          cd[8*i +: 8]   = 8'($urandom_range(0, 255));
        end
      end
      step(cv, cw, ca, cd, g);
    end
    idle(4);
    chk("drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
